// File: rtl/pack_channel_items_to_transmission.sv
// Packs variable-count, low-aligned channel items into dense AXI-Stream beats.
// Ports:
//   axis_aclk, axis_reset         : clock, async active-high reset
//   s_item_data/count/last/valid  : input beat (count = valid low items, clamped)
//   s_ready                       : input accepted when s_valid && s_ready
//   m_axis_tdata/tkeep/tlast/tvalid, m_axis_tready : registered AXI-Stream output
module pack_channel_items_to_transmission #(
  parameter int unsigned TDATA_WIDTH = 256,
  parameter int unsigned ITEM_WIDTH  = 8,
  localparam int unsigned ITEM_COUNT = TDATA_WIDTH / ITEM_WIDTH,
  localparam int unsigned COUNT_BITS = $clog2(ITEM_COUNT + 1),
  localparam int unsigned KEEP_WIDTH = TDATA_WIDTH / 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_reset,
  input  logic [TDATA_WIDTH-1:0] s_item_data,
  input  logic [COUNT_BITS-1:0]  s_item_count,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int unsigned BYTES_PER_ITEM = ITEM_WIDTH / 8;
  localparam int unsigned SUM_BITS       = COUNT_BITS + 1;
  localparam int unsigned SHIFT_BITS     = $clog2(2 * TDATA_WIDTH);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [TDATA_WIDTH-1:0]  acc_q, acc_d;
  logic [COUNT_BITS-1:0]   fill_q, fill_d;
  logic [TDATA_WIDTH-1:0]  res_q, res_d;
  logic [COUNT_BITS-1:0]   res_cnt_q, res_cnt_d;
  logic [TDATA_WIDTH-1:0]  tdata_d;
  logic [KEEP_WIDTH-1:0]   tkeep_d;
  logic                    tlast_d;
  logic                    tvalid_d;

  logic [COUNT_BITS-1:0]    n_clamped;
  logic [TDATA_WIDTH-1:0]   in_masked;
  logic [SHIFT_BITS-1:0]    shift;
  logic [2*TDATA_WIDTH-1:0] merged;
  logic [SUM_BITS-1:0]      sum;
  logic [COUNT_BITS-1:0]    rem;
  logic                     accept;
  logic                     drain;

  // Byte enables covering the given number of low items.
  function automatic logic [KEEP_WIDTH-1:0] keep_for(input logic [COUNT_BITS-1:0] items);
    logic [KEEP_WIDTH-1:0] k;
    k = '0;
    for (int unsigned b = 0; b < KEEP_WIDTH; b++) begin
      k[b] = (b < 32'(items) * BYTES_PER_ITEM);
    end
    return k;
  endfunction

  assign s_ready = !axis_reset && (state_q == ACCUM) && (!m_axis_tvalid || m_axis_tready);
  assign accept  = s_valid && s_ready;
  assign drain   = m_axis_tvalid && m_axis_tready;

  // Append the masked input items above the accumulator; the high half holds overflow.
  always_comb begin
    n_clamped = (s_item_count > COUNT_BITS'(ITEM_COUNT)) ? COUNT_BITS'(ITEM_COUNT) : s_item_count;
    in_masked = '0;
    for (int unsigned i = 0; i < ITEM_COUNT; i++) begin
      if (i < 32'(n_clamped)) begin
        in_masked[i*ITEM_WIDTH +: ITEM_WIDTH] = s_item_data[i*ITEM_WIDTH +: ITEM_WIDTH];
      end
    end
    shift  = SHIFT_BITS'(fill_q) * SHIFT_BITS'(ITEM_WIDTH);
    // acc_q is zero above the fill point, so OR-merging is exact.
    merged = {{TDATA_WIDTH{1'b0}}, acc_q} | ({{TDATA_WIDTH{1'b0}}, in_masked} << shift);
    sum    = SUM_BITS'(fill_q) + SUM_BITS'(n_clamped);
    rem    = COUNT_BITS'(sum - SUM_BITS'(ITEM_COUNT));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    tdata_d   = m_axis_tdata;
    tkeep_d   = m_axis_tkeep;
    tlast_d   = m_axis_tlast;
    tvalid_d  = drain ? 1'b0 : m_axis_tvalid;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (sum < SUM_BITS'(ITEM_COUNT)) begin
            if (!s_last) begin
              acc_d  = merged[TDATA_WIDTH-1:0];
              fill_d = COUNT_BITS'(sum);
            end else begin
              // Partial closing beat; sum == 0 yields the zero-length terminator.
              tdata_d  = merged[TDATA_WIDTH-1:0];
              tkeep_d  = keep_for(COUNT_BITS'(sum));
              tlast_d  = 1'b1;
              tvalid_d = 1'b1;
              acc_d    = '0;
              fill_d   = '0;
            end
          end else begin
            tdata_d  = merged[TDATA_WIDTH-1:0];
            tkeep_d  = '1;
            tvalid_d = 1'b1;
            if (!s_last) begin
              tlast_d = 1'b0;
              acc_d   = merged[2*TDATA_WIDTH-1:TDATA_WIDTH];
              fill_d  = rem;
            end else if (rem == '0) begin
              tlast_d = 1'b1;
              acc_d   = '0;
              fill_d  = '0;
            end else begin
              // Overflowing last input: park the tail until the full beat drains.
              tlast_d   = 1'b0;
              res_d     = merged[2*TDATA_WIDTH-1:TDATA_WIDTH];
              res_cnt_d = rem;
              acc_d     = '0;
              fill_d    = '0;
              state_d   = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (drain) begin
          tdata_d   = res_q;
          tkeep_d   = keep_for(res_cnt_q);
          tlast_d   = 1'b1;
          tvalid_d  = 1'b1;
          res_d     = '0;
          res_cnt_d = '0;
          fill_d    = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and output registers.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q       <= ACCUM;
      acc_q         <= '0;
      fill_q        <= '0;
      res_q         <= '0;
      res_cnt_q     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      fill_q        <= fill_d;
      res_q         <= res_d;
      res_cnt_q     <= res_cnt_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tkeep  <= tkeep_d;
      m_axis_tlast  <= tlast_d;
      m_axis_tvalid <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_pack_channel_items_to_transmission.sv
// Scoreboard bench for pack_channel_items_to_transmission (default parameters).
module tb_pack_channel_items_to_transmission;

  logic         clk;
  logic         axis_reset;
  logic [255:0] s_item_data;
  logic [5:0]   s_item_count;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    tlast_seen = 0;
  bit    rand_mode = 0;

  pack_channel_items_to_transmission dut (
    .axis_aclk     (clk),
    .axis_reset    (axis_reset),
    .s_item_data   (s_item_data),
    .s_item_count  (s_item_count),
    .s_last        (s_last),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: held high, or random stalls (~25%).
  always @(negedge clk) m_axis_tready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;

  // Beat holding cnt sequential item values starting at first.
  function automatic beat_t mk_beat(input logic [7:0] first, input int cnt, input bit last);
    beat_t b;
    b = '0;
    for (int i = 0; i < cnt; i++) begin
      b.data[i*8 +: 8] = first + 8'(i);
      b.keep[i]        = 1'b1;
    end
    b.last = last;
    return b;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected beats of a packet whose inputs carry ns[k] sequential items from first.
  task automatic push_pkt(input int ns[$], input logic [7:0] first);
    int total, nfull, rem;
    bit last_nonzero;
    total = 0;
    foreach (ns[k]) total += ns[k];
    nfull = total / 32;
    rem   = total % 32;
    last_nonzero = (ns[ns.size()-1] > 0);
    for (int b = 0; b < nfull; b++)
      exp_q.push_back(mk_beat(first + 8'(b*32), 32, (b == nfull-1) && (rem == 0) && last_nonzero));
    if (rem > 0) exp_q.push_back(mk_beat(first + 8'(nfull*32), rem, 1'b1));
    else if (total == 0 || !last_nonzero) exp_q.push_back(mk_beat(8'h00, 0, 1'b1));
  endtask

  // Present one input beat and hold it until accepted; garbage fills unused slots.
  task automatic drive(input int n, input bit last, input logic [7:0] first);
    int  guard;
    bit  done;
    @(negedge clk);
    s_valid      = 1'b1;
    s_last       = last;
    s_item_count = 6'(n);
    for (int i = 0; i < 32; i++) s_item_data[i*8 +: 8] = (i < n) ? first + 8'(i) : 8'hA5;
    guard = 0;
    done  = 0;
    while (!done) begin
      #4;
      if (s_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        guard++;
        if (guard > 1000) begin
          checks++;
          errors++;
          $display("FAIL drive_timeout actual=s_ready_low required=accept_within_1000");
          @(posedge clk);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid      = 1'b0;
    s_last       = 1'b0;
    s_item_count = '0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
  endtask

  // Monitor: sample just before each rising edge; check stall stability and handshaked beats.
  initial begin : monitor
    beat_t cur, prev, e;
    bit    prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      #4;
      if (axis_reset) begin
        prev_stall = 0;
      end else begin
        cur.data = m_axis_tdata;
        cur.keep = m_axis_tkeep;
        cur.last = m_axis_tlast;
        if (prev_stall) begin
          checks++;
          if (cur !== prev) begin
            errors++;
            $display("FAIL stall_stable actual=%0h required=%0h", cur, prev);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev       = cur;
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axis_tlast) tlast_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=no_beat", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL beat actual=%0h required=%0h", cur, e);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int          ns[$];
    int          base;
    logic [7:0]  val;
    int          tot;
    axis_reset   = 1'b1;
    s_valid      = 1'b0;
    s_last       = 1'b0;
    s_item_count = '0;
    s_item_data  = '0;

    // Reset values
    @(negedge clk);
    #4;
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_tdata",  m_axis_tdata, 256'(0));
    chk("rst_tkeep",  256'(m_axis_tkeep), 256'(0));
    chk("rst_tlast",  256'(m_axis_tlast), 256'(0));
    chk("rst_s_ready", 256'(s_ready), 256'(0));
    @(negedge clk);
    axis_reset = 1'b0;
    repeat (2) @(posedge clk);

    // 11+11+10 fills exactly one beat, last on it
    exp_q.push_back(mk_beat(8'd0, 32, 1'b1));
    drive(11, 1'b0, 8'd0);
    drive(11, 1'b0, 8'd11);
    drive(10, 1'b1, 8'd22);
    idle();
    #4;
    chk("latency_tvalid", 256'(m_axis_tvalid), 256'(1));
    wait_drain();

    // 11+11+11 overflows: full beat then residual beat, one bubble
    exp_q.push_back(mk_beat(8'd0, 32, 1'b0));
    exp_q.push_back(mk_beat(8'd32, 1, 1'b1));
    drive(11, 1'b0, 8'd0);
    drive(11, 1'b0, 8'd11);
    drive(11, 1'b1, 8'd22);
    idle();
    #4;
    chk("flush_ready_low", 256'(s_ready), 256'(0));
    chk("flush_full_valid", 256'(m_axis_tvalid), 256'(1));
    @(negedge clk);
    #4;
    chk("flush_ready_back", 256'(s_ready), 256'(1));
    wait_drain();

    // Zero-length terminator
    exp_q.push_back(mk_beat(8'd0, 0, 1'b1));
    drive(0, 1'b1, 8'd7);
    idle();
    wait_drain();

    // Short packet: 5 items
    exp_q.push_back(mk_beat(8'h40, 5, 1'b1));
    drive(5, 1'b1, 8'h40);
    idle();
    wait_drain();

    // Count above ITEM_COUNT clamps to a full beat
    exp_q.push_back(mk_beat(8'h10, 32, 1'b1));
    drive(40, 1'b1, 8'h10);
    idle();
    wait_drain();

    // Reset mid-packet discards accumulated items
    drive(11, 1'b0, 8'h60);
    drive(11, 1'b0, 8'h6B);
    idle();
    axis_reset = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    chk("midrst_tvalid", 256'(m_axis_tvalid), 256'(0));
    @(negedge clk);
    axis_reset = 1'b0;
    exp_q.push_back(mk_beat(8'h80, 3, 1'b1));
    drive(3, 1'b1, 8'h80);
    idle();
    wait_drain();

    // 50 random packets under random downstream stalls
    base      = tlast_seen;
    rand_mode = 1;
    val       = 8'd0;
    for (int p = 0; p < 50; p++) begin
      ns.delete();
      tot = $urandom_range(1, 3);
      for (int k = 0; k < tot; k++) ns.push_back(int'($urandom_range(0, 32)));
      push_pkt(ns, val);
      for (int k = 0; k < tot; k++) begin
        drive(ns[k], k == tot - 1, val);
        val = val + 8'(ns[k]);
      end
    end
    idle();
    wait_drain();
    rand_mode = 0;
    chk("tlast_count", 256'(tlast_seen - base), 256'(50));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
